// File: rtl/oam_dma_arbiter.sv
// Sprite DMA engine and CPU bus arbiter: halts the CPU on a $4014 write and
// copies one page of memory into the PPU OAM data port, otherwise passes the CPU bus through.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_COUNT    = 256
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_r_nw,
  input  logic [7:0]  bus_din,
  output logic        dma_active
);

  // XFER_COUNT is a power of two, so XFER_COUNT-1 doubles as the index wrap mask.
  localparam logic [7:0] IDX_LAST = 8'(XFER_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic       parity_q;
  logic       cpu_rdy_q;
  logic       trigger;

  assign trigger = !cpu_r_nw && (cpu_addr == DMA_REG_ADDR);

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          page_d  = cpu_dout;
          state_d = S_HALT_WAIT;
        end
      end
      S_HALT_WAIT: begin
        // The first CPU read here is the halted cycle; a put now means the next cycle is a get.
        if (cpu_r_nw) begin
          state_d = parity_q ? S_READ : S_ALIGN;
        end
      end
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        latch_d = bus_din;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = (idx_q + 8'd1) & IDX_LAST;
        state_d = (idx_q == IDX_LAST) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_ph1) begin
    if (rst) begin
      state_q   <= S_IDLE;
      page_q    <= 8'd0;
      idx_q     <= 8'd0;
      latch_q   <= 8'd0;
      parity_q  <= 1'b0;
      cpu_rdy_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      latch_q   <= latch_d;
      parity_q  <= ~parity_q;
      cpu_rdy_q <= (state_d == S_IDLE);
    end
  end

  always_comb begin
    bus_addr   = cpu_addr;
    bus_dout   = cpu_dout;
    bus_r_nw   = cpu_r_nw;
    dma_active = 1'b0;
    case (state_q)
      S_ALIGN: begin
        bus_r_nw   = 1'b1;
        dma_active = 1'b1;
      end
      S_READ: begin
        bus_addr   = {page_q, idx_q};
        bus_r_nw   = 1'b1;
        dma_active = 1'b1;
      end
      S_WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_dout   = latch_q;
        bus_r_nw   = 1'b0;
        dma_active = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_rdy = cpu_rdy_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: vector table for idle pass-through plus
// hand-written transfer sequences against a memory returning addr[7:0]^8'h5A.
module tb_oam_dma_arbiter;

  logic        clk_ph1 = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h8000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_r_nw = 1'b1;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_r_nw;
  logic [7:0]  bus_din;
  logic        dma_active;

  int          nchk = 0;
  int          nerr = 0;
  int          wr2004 = 0;
  int          zero_hits = 0;
  logic        mpar = 1'b0;
  logic [15:0] first_rd;
  logic [15:0] last_rd;

  oam_dma_arbiter dut (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_r_nw  (cpu_r_nw),
    .cpu_rdy   (cpu_rdy),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_r_nw  (bus_r_nw),
    .bus_din   (bus_din),
    .dma_active(dma_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  assign bus_din = bus_addr[7:0] ^ 8'h5A;

  // Expected get/put phase: 0 on the cycle after a reset edge, then alternating.
  always @(posedge clk_ph1) begin
    if (rst) mpar <= 1'b0;
    else     mpar <= ~mpar;
  end

  always @(negedge clk_ph1) begin
    if (!rst) begin
      if (bus_r_nw === 1'b0 && bus_addr === 16'h2004) wr2004++;
      if (dma_active === 1'b1 && bus_addr === 16'h0000) zero_hits++;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    cpu_addr = a;
    cpu_dout = d;
    cpu_r_nw = rnw;
  endtask

  task automatic next_cycle();
    @(posedge clk_ph1);
    #1;
  endtask

  // Runs one transfer; starts and ends just after a rising edge.
  task automatic xfer(input logic [7:0] pg, input bit get_halt, input int nwr,
                      input bit dup, input int abort_at, input string tag);
    int   lo, pt, rd, wr, par, act, g, w0, exp_lo;
    bit   aborted;
    logic tp;
    lo = 0; pt = 0; rd = 0; wr = 0; par = 0; act = 0; g = 0; aborted = 0;
    exp_lo = (get_halt ? 514 : 513) + nwr;
    tp = get_halt ? 1'((1 + nwr) % 2) : 1'(nwr % 2);
    drive(16'h8123, 8'hEE, 1'b1);
    while (mpar !== tp && g < 3) begin
      next_cycle();
      g++;
    end
    w0 = wr2004;
    drive(16'h4014, pg, 1'b0);
    @(negedge clk_ph1);
    if (bus_addr !== 16'h4014 || bus_r_nw !== 1'b0 || bus_dout !== pg) pt++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) act++;
    next_cycle();
    for (int i = 0; i < nwr; i++) begin
      if (dup && i == 0) drive(16'h4014, 8'h07, 1'b0);
      else               drive(16'h01F0 + 16'(i), 8'hC0 + 8'(i), 1'b0);
      @(negedge clk_ph1);
      if (bus_addr !== cpu_addr || bus_dout !== cpu_dout || bus_r_nw !== 1'b0) pt++;
      if (dma_active !== 1'b0) act++;
      if (cpu_rdy === 1'b0) lo++;
      next_cycle();
    end
    drive(16'h8123, 8'hEE, 1'b1);
    @(negedge clk_ph1);
    if (bus_addr !== 16'h8123 || bus_r_nw !== 1'b1 || bus_dout !== 8'hEE) pt++;
    if (dma_active !== 1'b0) act++;
    if (cpu_rdy === 1'b0) lo++;
    next_cycle();
    if (get_halt) begin
      @(negedge clk_ph1);
      chk({tag, "_align_addr"}, 32'(bus_addr), 32'h8123);
      chk({tag, "_align_rnw"}, 32'(bus_r_nw), 32'd1);
      chk({tag, "_align_active"}, 32'(dma_active), 32'd1);
      if (cpu_rdy === 1'b0) lo++;
      next_cycle();
    end
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_ph1);
      if (i == 0)   first_rd = bus_addr;
      if (i == 255) last_rd  = bus_addr;
      if (bus_addr !== {pg, 8'(i)} || bus_r_nw !== 1'b1) rd++;
      if (mpar !== 1'b0) par++;
      if (dma_active !== 1'b1) act++;
      if (cpu_rdy === 1'b0) lo++;
      next_cycle();
      @(negedge clk_ph1);
      if (bus_addr !== 16'h2004 || bus_r_nw !== 1'b0 || bus_dout !== (8'(i) ^ 8'h5A)) wr++;
      if (mpar !== 1'b1) par++;
      if (dma_active !== 1'b1) act++;
      if (cpu_rdy === 1'b0) lo++;
      next_cycle();
      if (abort_at > 0 && i + 1 == abort_at) begin
        aborted = 1;
        break;
      end
    end
    if (aborted) begin
      rst = 1'b1;
      @(negedge clk_ph1);
      next_cycle();
      rst = 1'b0;
      @(negedge clk_ph1);
      chk({tag, "_rst_rdy"}, 32'(cpu_rdy), 32'd1);
      chk({tag, "_rst_active"}, 32'(dma_active), 32'd0);
      chk({tag, "_rst_bus_addr"}, 32'(bus_addr), 32'h8123);
      chk({tag, "_rst_bus_rnw"}, 32'(bus_r_nw), 32'd1);
      repeat (4) next_cycle();
      @(negedge clk_ph1);
      chk({tag, "_rst_wr_count"}, 32'(wr2004 - w0), 32'(abort_at));
      chk({tag, "_rst_rdy_late"}, 32'(cpu_rdy), 32'd1);
      next_cycle();
    end else begin
      @(negedge clk_ph1);
      chk({tag, "_end_rdy"}, 32'(cpu_rdy), 32'd1);
      chk({tag, "_end_active"}, 32'(dma_active), 32'd0);
      chk({tag, "_end_bus_addr"}, 32'(bus_addr), 32'h8123);
      chk({tag, "_halt_cycles"}, 32'(lo), 32'(exp_lo));
      chk({tag, "_wr_count"}, 32'(wr2004 - w0), 32'd256);
      next_cycle();
    end
    chk({tag, "_passthru_errs"}, 32'(pt), 32'd0);
    chk({tag, "_read_errs"}, 32'(rd), 32'd0);
    chk({tag, "_write_errs"}, 32'(wr), 32'd0);
    chk({tag, "_parity_errs"}, 32'(par), 32'd0);
    chk({tag, "_active_errs"}, 32'(act), 32'd0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rnw;
    logic        rdy;
    logic        act;
    logic [15:0] ba;
    logic [7:0]  bd;
    logic        brnw;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{16'h8000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b1};
    vt[1] = '{16'h4014, 8'h55, 1'b1, 1'b1, 1'b0, 16'h4014, 8'h55, 1'b1};
    vt[2] = '{16'h4015, 8'h33, 1'b0, 1'b1, 1'b0, 16'h4015, 8'h33, 1'b0};
    vt[3] = '{16'h4013, 8'h44, 1'b0, 1'b1, 1'b0, 16'h4013, 8'h44, 1'b0};
    vt[4] = '{16'h1014, 8'h77, 1'b0, 1'b1, 1'b0, 16'h1014, 8'h77, 1'b0};
    vt[5] = '{16'hC014, 8'h99, 1'b1, 1'b1, 1'b0, 16'hC014, 8'h99, 1'b1};

    // Reset, with a $4014 write presented during reset: reset must win.
    rst = 1'b1;
    drive(16'h4014, 8'h02, 1'b0);
    next_cycle();
    @(negedge clk_ph1);
    chk("reset_rdy", 32'(cpu_rdy), 32'd1);
    chk("reset_active", 32'(dma_active), 32'd0);
    chk("reset_bus_addr", 32'(bus_addr), 32'h4014);
    chk("reset_bus_rnw", 32'(bus_r_nw), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(16'h8000, 8'h00, 1'b1);
    @(negedge clk_ph1);
    chk("rst_vs_trig_rdy0", 32'(cpu_rdy), 32'd1);
    next_cycle();
    @(negedge clk_ph1);
    chk("rst_vs_trig_rdy1", 32'(cpu_rdy), 32'd1);
    chk("rst_vs_trig_active", 32'(dma_active), 32'd0);
    next_cycle();

    for (int k = 0; k < 6; k++) begin
      drive(vt[k].a, vt[k].d, vt[k].rnw);
      @(negedge clk_ph1);
      chk($sformatf("vec%0d_rdy", k), 32'(cpu_rdy), 32'(vt[k].rdy));
      chk($sformatf("vec%0d_active", k), 32'(dma_active), 32'(vt[k].act));
      chk($sformatf("vec%0d_bus_addr", k), 32'(bus_addr), 32'(vt[k].ba));
      chk($sformatf("vec%0d_bus_dout", k), 32'(bus_dout), 32'(vt[k].bd));
      chk($sformatf("vec%0d_bus_rnw", k), 32'(bus_r_nw), 32'(vt[k].brnw));
      next_cycle();
    end

    xfer(8'h02, 1'b0, 0, 1'b0, 0, "aligned");
    chk("aligned_first_rd", 32'(first_rd), 32'h0200);
    xfer(8'h02, 1'b1, 0, 1'b0, 0, "misaligned");
    xfer(8'h02, 1'b0, 2, 1'b1, 0, "extend");
    chk("extend_first_rd", 32'(first_rd), 32'h0200);
    chk("extend_last_rd", 32'(last_rd), 32'h02FF);
    xfer(8'hFF, 1'b0, 0, 1'b0, 0, "wrap");
    chk("wrap_last_rd", 32'(last_rd), 32'hFFFF);
    chk("wrap_zero_access", 32'(zero_hits), 32'd0);
    xfer(8'h11, 1'b0, 0, 1'b0, 40, "abort");
    xfer(8'h03, 1'b0, 0, 1'b0, 0, "restart");
    chk("restart_first_rd", 32'(first_rd), 32'h0300);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Sprite (OAM) DMA engine and CPU bus arbiter, placed between the CPU core and the system bus.
- A CPU write to $4014 starts a transfer. The block then:
  - halts the CPU through RDY;
  - takes ownership of the address/data/R_nW bus;
  - copies 256 bytes from page $XX00–$XXFF to the PPU OAM data port at $2004.
- Outside a transfer it is a transparent pass-through of CPU bus signals.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_COUNT, 256, bytes per transfer; must be a power of two, at most 256.

Ports:
- clk_ph1  in  1  system clock, one CPU cycle per rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- cpu_r_nw  in  1  CPU read(1)/write(0).
- cpu_rdy  out  1  CPU ready; 0 halts the CPU on its next read cycle.
- bus_addr  out  16  arbitrated system address.
- bus_dout  out  8  arbitrated system write data.
- bus_r_nw  out  1  arbitrated read/write.
- bus_din  in  8  system read data, valid by end of cycle.
- dma_active  out  1  high while the DMA owns the bus (ALIGN/READ/WRITE).

Behaviour:
- Reset values (rst sampled high at clk_ph1 edge):
  - state=IDLE, cpu_rdy=1, dma_active=0, idx=0, parity=0, page=0, data latch=0.
  - Bus outputs are combinational pass-through in IDLE.
- parity register:
  - Toggles every clock after reset. 0=get cycle, 1=put cycle.
  - Free-running; never reset by a transfer.
- Bus mux (combinational):
  - IDLE/HALT_WAIT: bus_* = cpu_*.
  - ALIGN: bus_addr=cpu_addr, bus_r_nw=1, bus_dout=cpu_dout (dummy read).
  - READ: bus_addr={page, idx}, bus_r_nw=1.
  - WRITE: bus_addr=OAM_DATA_ADDR, bus_dout=latch, bus_r_nw=0.
- cpu_rdy is registered: 0 in every state except IDLE.
- States and transitions:
  - IDLE:
    - A cycle with cpu_r_nw=0 and cpu_addr=DMA_REG_ADDR latches page=cpu_dout and goes to HALT_WAIT.
    - The CPU write itself passes through to the bus unchanged.
  - HALT_WAIT:
    - cpu_rdy=0. The CPU may still be finishing write cycles (e.g. RMW, interrupt push).
    - While cpu_r_nw=0: stay, pass through.
    - When cpu_r_nw=1, this cycle is the CPU's halted read.
      - If the next cycle is a get (current parity=1), go to READ.
      - Otherwise go to ALIGN.
    - Additional $4014 writes seen in HALT_WAIT are ignored; page is held.
  - ALIGN: one dummy cycle, then READ.
  - READ: latch <= bus_din at cycle end, then WRITE.
  - WRITE:
    - idx increments modulo XFER_COUNT.
    - If idx was XFER_COUNT-1, go to IDLE (cpu_rdy=1, dma_active=0 on the next cycle, idx=0).
    - Otherwise go to READ.
- Invariants:
  - READ always falls on parity=0 and WRITE on parity=1.
  - Total halt, trigger-write excluded, with no pending CPU writes: 1 + 512 = 513 cycles if the halt cycle is on a put; 514 if it is on a get.
  - Each extra CPU write cycle in HALT_WAIT adds 1.
- Address wrap:
  - {page, idx} never carries into page. page=$FF reads $FF00–$FFFF.
- Reset mid-transfer:
  - Immediate return to IDLE; the transfer is abandoned.
  - cpu_rdy=1 the following cycle; no further $2004 writes.
- Simultaneous rst and a $4014 write: reset wins, no transfer.
- A $4014 read (cpu_r_nw=1) never triggers.

Test Plan:
- Trigger with an aligned halt:
  - Reset, run until parity=0, CPU writes $02 to $4014.
  - Next cycle is a CPU read, so that halt cycle falls on a put (parity=1).
  - Required: no ALIGN; READ from $0200 on the following cycle; 256 WRITEs to $2004.
  - Data written must equal a memory model where byte = addr[7:0]^8'h5A, i.e. $5A,$5B,…,$A5.
  - cpu_rdy low exactly 513 cycles.
- Misaligned trigger:
  - Same setup, but the halt cycle falls on a get (parity=0).
  - Required: one ALIGN dummy read at cpu_addr; cpu_rdy low 514 cycles; every READ on parity=0, every WRITE on parity=1.
- CPU write extension:
  - After the trigger, hold cpu_r_nw=0 for 2 cycles, with a second $4014 write of $07 among them.
  - Required: both writes appear on the bus; page stays $02; halt lengthens by 2.
  - First DMA read address is $0200.
- Page wrap, page=$FF:
  - Required: last READ address $FFFF, next WRITE to $2004.
  - Then IDLE with cpu_rdy=1 and bus_addr=cpu_addr; no access to $0000.
- Reset mid-transfer:
  - Assert rst for 1 cycle after 40 WRITEs.
  - Required: next cycle cpu_rdy=1, dma_active=0, bus pass-through.
  - Count of $2004 writes stays 40.
  - A new trigger with $03 restarts at $0300.
- Non-trigger accesses:
  - CPU read of $4014, and a write to $4015.
  - Required: state stays IDLE, cpu_rdy=1 throughout.
